// File: rtl/prime_pkg.sv
// Shared definitions for the prime scanner: number width and scan FSM states.
package prime_pkg;

   localparam int NUM_W = 32;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SCAN  = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

endpackage

// File: rtl/prime_fifo.sv
// Synchronous FIFO for found primes; a push is accepted when full only if a pop occurs in the same cycle.
module prime_fifo
   import prime_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic             pop,
   input  logic [NUM_W-1:0] wdata,
   output logic [NUM_W-1:0] rdata,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

   logic [NUM_W-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW:0]      count;
   logic             do_pop;
   logic             do_push;

   assign full    = (count == FULL_CNT);
   assign empty   = (count == {(AW+1){1'b0}});
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign rdata   = mem[rd_ptr];

   // storage array, no reset needed since reads are gated by empty
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= wdata;
      end
   end

   // pointer and occupancy bookkeeping
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= {AW{1'b0}};
         rd_ptr <= {AW{1'b0}};
         count  <= {(AW+1){1'b0}};
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + {{(AW-1){1'b0}}, 1'b1};
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + {{(AW-1){1'b0}}, 1'b1};
         end
         if (do_push && !do_pop) begin
            count <= count + {{AW{1'b0}}, 1'b1};
         end else if (!do_push && do_pop) begin
            count <= count - {{AW{1'b0}}, 1'b1};
         end
      end
   end

endmodule

// File: rtl/prime_scan.sv
// Scans [lo,hi] against an external combinational prime checker and streams primes out through a FIFO.
// Optional PRIME_SCAN_SKIP_EVEN_EN: step by 2 over odd candidates (2 still visited when lo<=2).
module prime_scan
   import prime_pkg::*;
#(
   parameter int FIFO_DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [NUM_W-1:0] lo,
   input  logic [NUM_W-1:0] hi,
   output logic [NUM_W-1:0] num,
   input  logic             is_prime,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [NUM_W-1:0] out_data,
   output logic             busy,
   output logic             done,
   output logic [NUM_W-1:0] prime_count
);

   state_t           state_r, state_n;
   logic [NUM_W-1:0] num_r, num_n;
   logic [NUM_W-1:0] hi_r, hi_n;
   logic [NUM_W-1:0] cnt_r, cnt_n;
   logic [NUM_W:0]   step_s;
   logic             last_s;
   logic             push_s;
   logic             pop_s;
   logic             fifo_full;
   logic             fifo_empty;

   // next candidate, kept one bit wider so stepping past 0xFFFFFFFF is seen as termination
   always_comb begin
`ifdef PRIME_SCAN_SKIP_EVEN_EN
      if (!num_r[0] || (num_r < 32'd3)) begin
         step_s = {1'b0, num_r} + 33'd1;
      end else begin
         step_s = {1'b0, num_r} + 33'd2;
      end
`else
      step_s = {1'b0, num_r} + 33'd1;
`endif
      last_s = (step_s > {1'b0, hi_r});
   end

   // scan FSM next-state and datapath
   always_comb begin
      state_n = state_r;
      num_n   = num_r;
      hi_n    = hi_r;
      cnt_n   = cnt_r;
      push_s  = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (start) begin
               cnt_n = 32'd0;
               if (lo <= hi) begin
                  num_n   = lo;
                  hi_n    = hi;
                  state_n = ST_SCAN;
               end else begin
                  state_n = ST_DONE;
               end
            end else begin
               state_n = ST_IDLE;
            end
         end
         ST_SCAN: begin
            if (is_prime && fifo_full && !out_ready) begin
               state_n = ST_SCAN;
            end else begin
               push_s = is_prime;
               if (is_prime) begin
                  cnt_n = cnt_r + 32'd1;
               end else begin
                  cnt_n = cnt_r;
               end
               if (last_s) begin
                  state_n = ST_DRAIN;
               end else begin
                  num_n = step_s[NUM_W-1:0];
               end
            end
         end
         ST_DRAIN: begin
            if (fifo_empty) begin
               state_n = ST_DONE;
            end else begin
               state_n = ST_DRAIN;
            end
         end
         ST_DONE: begin
            state_n = ST_IDLE;
         end
         default: begin
            state_n = ST_IDLE;
         end
      endcase
   end

   // state registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= ST_IDLE;
         num_r   <= 32'd0;
         hi_r    <= 32'd0;
         cnt_r   <= 32'd0;
      end else begin
         state_r <= state_n;
         num_r   <= num_n;
         hi_r    <= hi_n;
         cnt_r   <= cnt_n;
      end
   end

   assign pop_s = !fifo_empty && out_ready;

   prime_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push_s),
      .pop   (pop_s),
      .wdata (num_r),
      .rdata (out_data),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   assign num         = num_r;
   assign prime_count = cnt_r;
   assign out_valid   = !fifo_empty;
   assign busy        = (state_r == ST_SCAN) || (state_r == ST_DRAIN);
   assign done        = (state_r == ST_DONE);

endmodule

// File: doc/prime_scan.md
PRIME_SCAN -- requirements
Module: prime_scan

Interface
REQ-001 The block SHALL have parameter FIFO_DEPTH, default 4, meaning output FIFO entries (power of two, at least 2).
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1, synchronous active-high reset.
REQ-004 The block SHALL have port start, input, 1, one-cycle request to begin a scan; honoured only in IDLE.
REQ-005 The block SHALL have ports lo and hi, input, 32 each, the inclusive scan range, sampled on an accepted start.
REQ-006 The block SHALL have port num, output, 32, the candidate driven to the combinational prime_checker.
REQ-007 The block SHALL have port is_prime, input, 1, the prime_checker verdict for num, valid in the same cycle.
REQ-008 The block SHALL have ports out_valid/out_ready (output/input, 1) and out_data (output, 32), a prime stream from the FIFO head.
REQ-009 The block SHALL have ports busy (output, 1), done (output, 1-cycle pulse) and prime_count (output, 32, primes pushed in the current/last scan).

Function
REQ-010 The FSM SHALL have the states IDLE, SCAN, DRAIN and DONE.
REQ-011 On start in IDLE with lo <= hi, the FSM SHALL latch lo/hi, set num=lo, clear prime_count, and enter SCAN next cycle; while IDLE, num holds its last value.
REQ-012 On start in IDLE with lo > hi, the FSM SHALL go to DONE directly, with prime_count=0 and no pushes.
REQ-013 In SCAN, each cycle the FSM SHALL evaluate num: if is_prime=0, advance; if is_prime=1 and FIFO not full, push num, increment prime_count and advance; if is_prime=1 and FIFO full, stall with num held.
REQ-014 Advancing when num==hi SHALL enter DRAIN instead of incrementing, so num never wraps past 0xFFFFFFFF.
REQ-015 A FIFO push and pop in the same cycle SHALL be allowed when full or empty-with-push; occupancy is unchanged and a pop from empty SHALL never occur.
REQ-016 DRAIN SHALL wait until the FIFO is empty and then enter DONE.
REQ-017 DONE SHALL last exactly one cycle, asserting done=1, then return to IDLE.
REQ-018 busy SHALL be 1 in SCAN and DRAIN and 0 otherwise; start while busy SHALL be ignored.
REQ-019 out_valid SHALL equal FIFO non-empty; out_data SHALL be stable while out_valid=1 and out_ready=0.
REQ-020 Throughput SHALL be one candidate per cycle absent backpressure; first push latency SHALL be 1 cycle after entering SCAN.

Reset
REQ-021 rst SHALL force IDLE, num=0, busy=0, done=0, prime_count=0, out_valid=0, and flush the FIFO, including mid-scan.
REQ-022 rst asserted together with start SHALL win, so no scan begins.

Configuration
REQ-023 With PRIME_SCAN_SKIP_EVEN_EN defined, after the first candidate the scan SHALL step num by 2, visiting only odd values plus 2 when lo<=2.
REQ-024 With PRIME_SCAN_SKIP_EVEN_EN defined, termination SHALL occur when the next odd step would exceed hi or overflow 32 bits.
REQ-025 Without PRIME_SCAN_SKIP_EVEN_EN, every integer in [lo,hi] SHALL be visited; the output stream SHALL be identical in both builds.

Structure
REQ-026 Package prime_pkg SHALL hold the FSM state enum and the 32-bit number width constant; prime_checker imports the same width.
REQ-027 The FIFO SHALL be a separate sub-module prime_fifo (parameter DEPTH, width 32, push/pop/full/empty).

Verification
REQ-028 Scenario: lo=10, hi=20, out_ready=1 -> out_data 11,13,17,19 in order; prime_count=4; a single done pulse.
REQ-029 Scenario: lo=18, hi=18 -> no out_valid; done after SCAN+DRAIN; prime_count=0.
REQ-030 Scenario: lo=2, hi=30, FIFO_DEPTH=4, out_ready=0 -> stall with num=11 and FIFO holding 2,3,5,7; after out_ready=1, all 10 primes through 29 are delivered with no loss or duplication.
REQ-031 Scenario: lo=0xFFFFFFFB, hi=0xFFFFFFFF -> exactly one output 4294967291; DONE reached; num never wraps to 0.
REQ-032 Scenario: lo=25, hi=5 -> done one cycle after start; busy never asserted; prime_count=0.
REQ-033 Scenario: rst mid-scan of lo=100, hi=200 -> next cycle IDLE, out_valid=0, prime_count=0; a new start rescans correctly.
